// File: rtl/counter_pkg.sv
// Shared types for the loadable up/down counter.
// Mode is captured at load time and steers the step direction and the terminal value.
package counter_pkg;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } mode_t;

endpackage

// File: rtl/counter_next_logic.sv
// Next-count and wrap computation for counter_updown_nb_rtl (combinational, 0 cycles).
// Load overrides stepping; the auto-reload path exists only with COUNTER_AUTO_RELOAD_EN.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] count,
  input  logic [NBITS-1:0] term,
`ifdef COUNTER_AUTO_RELOAD_EN
  input  logic [NBITS-1:0] reload,
`endif
  input  mode_t            mode,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  mode_t            load_mode,
  input  logic             en,
  output logic [NBITS-1:0] count_nxt,
  output logic             wrap
);

  logic done;

  always_comb begin
    done      = (count == term);
    count_nxt = count;
    wrap      = 1'b0;
    if (load) begin
      // Up mode always starts at zero; down mode starts at the loaded value.
      count_nxt = (load_mode == MODE_UP) ? '0 : load_val;
    end else if (en && !done) begin
      count_nxt = (mode == MODE_UP) ? count + NBITS'(1) : count - NBITS'(1);
    end
`ifdef COUNTER_AUTO_RELOAD_EN
    else if (en) begin
      count_nxt = (mode == MODE_UP) ? '0 : reload;
    end
    wrap = en & done & ~load;
`endif
  end

endmodule

// File: rtl/counter_updown_nb_rtl.sv
// Loadable up/down counter with terminal detect; optional auto-reload via COUNTER_AUTO_RELOAD_EN.
// Latency: count/done update one cycle after a load or step edge; wrap is combinational.
module counter_updown_nb_rtl
  import counter_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] in,
  input  logic             dir,
  input  logic             en,
  output logic [NBITS-1:0] count,
  output logic             done,
  output logic             wrap
);

  logic [NBITS-1:0] count_q;
  logic [NBITS-1:0] term_q;
  logic [NBITS-1:0] count_nxt;
  mode_t            mode_q;
  mode_t            load_mode;

`ifdef COUNTER_AUTO_RELOAD_EN
  logic [NBITS-1:0] reload_q;
`endif

  assign load_mode = mode_t'(dir);

  counter_next_logic #(
    .NBITS(NBITS)
  ) u_next (
    .count    (count_q),
    .term     (term_q),
`ifdef COUNTER_AUTO_RELOAD_EN
    .reload   (reload_q),
`endif
    .mode     (mode_q),
    .load     (load),
    .load_val (in),
    .load_mode(load_mode),
    .en       (en),
    .count_nxt(count_nxt),
    .wrap     (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      term_q  <= '0;
      mode_q  <= MODE_DOWN;
`ifdef COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      count_q <= count_nxt;
      if (load) begin
        // Down counts toward zero; up counts toward the loaded value.
        term_q <= (load_mode == MODE_UP) ? in : '0;
        mode_q <= load_mode;
`ifdef COUNTER_AUTO_RELOAD_EN
        reload_q <= in;
`endif
      end
    end
  end

  assign count = count_q;
  assign done  = (count_q == term_q);

endmodule

// File: tb/tb_counter_updown_nb_rtl.sv
// Bench for counter_updown_nb_rtl: directed vector table, max-range sequences, random vs model.
module tb_counter_updown_nb_rtl;

`ifdef COUNTER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, load, dir, en;
  logic [7:0] in;
  logic [7:0] count;
  logic       done, wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  counter_updown_nb_rtl #(.NBITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .in   (in),
    .dir  (dir),
    .en   (en),
    .count(count),
    .done (done),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic [7:0] in;
    logic       dir;
    logic       en;
    logic [7:0] cnt;   // count after the edge
    logic       done;  // done after the edge
    logic       wrap;  // wrap during the cycle, before the edge
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic r, input logic l, input logic [7:0] v,
                              input logic d, input logic e, input logic [7:0] c,
                              input logic dn, input logic w);
    vec_t t;
    t.name = nm; t.rst = r; t.load = l; t.in = v; t.dir = d; t.en = e;
    t.cnt = c; t.done = dn; t.wrap = w;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic r, input logic l, input logic [7:0] v, input logic d, input logic e);
    rst = r; load = l; in = v; dir = d; en = e;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference state for the random phase
  int m_c, m_t, m_r;
  bit m_up;
  bit m_valid;

  initial begin
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    next_edge();

    //   name           rst load in dir en  count                done  wrap
    add("rst",          1, 0, 8'd0, 0, 0, 8'd0,               1'b1, 1'b0);
    add("rst_en_hold",  0, 0, 8'd0, 0, 1, 8'd0,               1'b1, AR);
    add("dn_load3",     0, 1, 8'd3, 0, 1, 8'd3,               1'b0, 1'b0);
    add("dn_2",         0, 0, 8'd0, 0, 1, 8'd2,               1'b0, 1'b0);
    add("dn_1",         0, 0, 8'd0, 0, 1, 8'd1,               1'b0, 1'b0);
    add("dn_0",         0, 0, 8'd0, 0, 1, 8'd0,               1'b1, 1'b0);
    add("dn_term",      0, 0, 8'd0, 0, 1, AR ? 8'd3 : 8'd0,   !AR,  AR);
    add("up_load4",     0, 1, 8'd4, 1, 1, 8'd0,               1'b0, 1'b0);
    add("up_1",         0, 0, 8'd0, 0, 1, 8'd1,               1'b0, 1'b0);
    add("up_2",         0, 0, 8'd0, 0, 1, 8'd2,               1'b0, 1'b0);
    add("up_3",         0, 0, 8'd0, 0, 1, 8'd3,               1'b0, 1'b0);
    add("up_4",         0, 0, 8'd0, 0, 1, 8'd4,               1'b1, 1'b0);
    add("up_term",      0, 0, 8'd0, 0, 1, AR ? 8'd0 : 8'd4,   !AR,  AR);
    add("gate_load5",   0, 1, 8'd5, 0, 0, 8'd5,               1'b0, 1'b0);
    add("gate_hold1",   0, 0, 8'd0, 0, 0, 8'd5,               1'b0, 1'b0);
    add("gate_hold2",   0, 0, 8'd0, 0, 0, 8'd5,               1'b0, 1'b0);
    add("gate_step",    0, 0, 8'd0, 0, 1, 8'd4,               1'b0, 1'b0);
    add("mid_load2",    0, 1, 8'd2, 0, 1, 8'd2,               1'b0, 1'b0);
    add("mid_1",        0, 0, 8'd0, 0, 1, 8'd1,               1'b0, 1'b0);
    add("mid_0",        0, 0, 8'd0, 0, 1, 8'd0,               1'b1, 1'b0);
    add("rm_load5",     0, 1, 8'd5, 0, 1, 8'd5,               1'b0, 1'b0);
    add("rm_step",      0, 0, 8'd0, 0, 1, 8'd4,               1'b0, 1'b0);
    add("rm_rst",       1, 0, 8'd0, 0, 1, 8'd0,               1'b1, 1'b0);
    add("rm_after",     0, 0, 8'd0, 0, 1, 8'd0,               1'b1, AR);
    add("load0_up",     0, 1, 8'd0, 1, 1, 8'd0,               1'b1, 1'b0);
    add("load0_dn",     0, 1, 8'd0, 0, 0, 8'd0,               1'b1, 1'b0);
    add("ar_load2",     0, 1, 8'd2, 0, 1, 8'd2,               1'b0, 1'b0);
    add("ar_1",         0, 0, 8'd0, 0, 1, 8'd1,               1'b0, 1'b0);
    add("ar_0",         0, 0, 8'd0, 0, 1, 8'd0,               1'b1, 1'b0);
    add("ar_reload",    0, 0, 8'd0, 0, 1, AR ? 8'd2 : 8'd0,   !AR,  AR);
    add("ar_after",     0, 0, 8'd0, 0, 1, AR ? 8'd1 : 8'd0,   !AR,  1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].in, vecs[i].dir, vecs[i].en);
      @(negedge clk);
      chk({vecs[i].name, ".wrap"}, wrap, vecs[i].wrap);
      next_edge();
      chk({vecs[i].name, ".count"}, count, vecs[i].cnt);
      chk({vecs[i].name, ".done"}, done, vecs[i].done);
    end

    // Full-range down count from 255
    drive(1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    next_edge();
    chk("max_dn.load", count, 8'd255);
    load = 1'b0;
    next_edge();
    chk("max_dn.first", count, 8'd254);
    for (int k = 1; k < 255; k++) next_edge();
    chk("max_dn.count", count, 8'd0);
    chk("max_dn.done", done, 1'b1);

    // Full-range up count to 255
    drive(1'b0, 1'b1, 8'd255, 1'b1, 1'b1);
    next_edge();
    load = 1'b0;
    for (int k = 0; k < 254; k++) next_edge();
    chk("max_up.254", count, 8'd254);
    chk("max_up.254_done", done, 1'b0);
    next_edge();
    chk("max_up.count", count, 8'd255);
    chk("max_up.done", done, 1'b1);
    @(negedge clk);
    chk("max_up.wrap", wrap, AR);
    next_edge();
    chk("max_up.hold", count, AR ? 8'd0 : 8'd255);

    // Randomized traffic against the reference model
    m_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      logic       r, l, d, e, exp_w;
      logic [7:0] v;
      r = (k == 0) || ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 9) == 0);
      d = $urandom_range(0, 1);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      drive(r, l, v, d, e);
      @(negedge clk);
      if (m_valid) begin
        exp_w = AR && e && !l && (m_c == m_t);
        chk("rnd.count", count, m_c);
        chk("rnd.done", done, m_c == m_t);
        chk("rnd.wrap", wrap, exp_w);
      end
      if (r) begin
        m_c = 0; m_t = 0; m_r = 0; m_up = 0; m_valid = 1'b1;
      end else if (l) begin
        m_up = d;
        m_r  = v;
        m_c  = d ? 0 : v;
        m_t  = d ? v : 0;
      end else if (e) begin
        if (m_c != m_t) m_c = m_up ? m_c + 1 : m_c - 1;
        else if (AR) m_c = m_up ? 0 : m_r;
      end
      next_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
